ccr_unit: RTL and testbench
===========================

// Module: ccr_unit
// PURPOSE
//  Condition-code register for the pipeline; consumes the ALU's {carry, zero, neg} flag outputs.
//  Latches flags per executed op and resolves conditional jumps (JZ/JN/JC) against forwarded flags.
//  Clears the tested flag when a jump is taken; saves/restores flags for interrupt entry/RTI.
//  Sits in EX stage beside the ALU; feeds jump_taken to the fetch PC mux.
// PARAMETERS
//  OPW      4   width of ALU op code (same encoding the ALU decodes)
//  OP_SETC  11  op code that forces C=1
//  OP_CLRC  12  op code that forces C=0
// PORTS
//  clk          in   1    system clock, rising edge
//  rst_n        in   1    asynchronous active-low reset
//  stall        in   1    pipeline hold: state frozen, jump_taken forced 0
//  alu_op       in   OPW  op code of instruction in EX (0 = NOP)
//  alu_c        in   1    ALU carry flag
//  alu_z        in   1    ALU zero flag
//  alu_n        in   1    ALU negative flag
//  jmp_valid    in   1    conditional jump present this cycle
//  jmp_cond     in   2    01=JZ 10=JN 11=JC 00=unconditional
//  int_save     in   1    interrupt entry: copy flags to shadow
//  rti_restore  in   1    RTI: load flags from shadow
//  flags        out  3    {C,N,Z} registered flag state
//  jump_taken   out  1    combinational jump decision
// BEHAVIOUR
//  Reset: flags=3'b000, shadow=3'b000; jump_taken=0 while rst_n=0.
//  Per-op update mask (upd = {C,N,Z}):
//   ops 1,7,8          -> N,Z updated; C kept
//   ops 2,3,5,6        -> C,N,Z all updated
//   OP_SETC / OP_CLRC  -> C forced 1 / 0; N,Z kept
//   ops 0,4,9,10,13,14,15 -> no update
//  fwd = flags with this cycle's masked ALU update applied (combinational).
//  jump_taken = jmp_valid & ~stall & (cond==00 | cond==01&fwd.Z | cond==10&fwd.N | cond==11&fwd.C).
//  Taken conditional jump clears its tested bit in flags_next; clear beats ALU update of same bit.
//  Unconditional jump (00) never modifies flags.
//  flags_next priority (high->low): stall hold > rti_restore (=shadow) > jump clear > ALU update > hold.
//  rti_restore ignores alu_op/jump that cycle; jump_taken still evaluated from fwd.
//  int_save: shadow <= flags (pre-update register value) at edge; flags still update normally.
//  int_save & rti_restore same cycle: restore wins, shadow unchanged.
//  stall=1: flags and shadow hold, no jump clear, jump_taken=0.
//  Latency: flags visible 1 cycle after op; fwd path gives 0-cycle use for a jump in same cycle.
//  Async reset mid-operation: immediate return to reset values; pending save/restore discarded.
// STRUCTURE
//  Shared package: ALU op code localparams (OP_NOT..OP_CLRC), JCOND_* codes, flag bit indices
//   FLAG_Z=0, FLAG_N=1, FLAG_C=2. ALU and decoder import the same package.
//  One sub-module: ccr_update_mask (alu_op -> 3-bit update mask + set/clear C), combinational.
//  Top: forwarding mux, jump compare, flags/shadow registers with async clear.
// TESTING
//  Reset: rst_n=0 mid-run with flags=3'b111 -> flags=000, jump_taken=0 immediately.
//  Op 5 with alu_c=1,alu_z=0,alu_n=1 -> next flags=3'b110; then op 4 -> flags stay 110.
//  Op 7 with alu_z=1 while C=1 -> flags=3'b101 (C kept); then OP_CLRC -> flags=3'b001.
//  JZ same cycle as op 6 producing alu_z=1 (flags.Z was 0) -> jump_taken=1, next flags.Z=0.
//  flags=101, int_save then op 2 giving 010, then rti_restore -> flags=101 after restore.
//  stall=1 with jmp_valid JC, flags.C=1 -> jump_taken=0, flags unchanged; release -> taken, C=0.

Source files
------------

// File: rtl/ccr_unit_pkg.sv
// Shared ALU op codes, jump condition codes and flag bit positions.
// Imported by the ALU, the decoder and the condition-code register.
package ccr_unit_pkg;

  localparam int OPW = 4;

  localparam logic [OPW-1:0] OP_NOP  = 4'd0;
  localparam logic [OPW-1:0] OP_NOT  = 4'd1;
  localparam logic [OPW-1:0] OP_ADD  = 4'd2;
  localparam logic [OPW-1:0] OP_SUB  = 4'd3;
  localparam logic [OPW-1:0] OP_LD   = 4'd4;
  localparam logic [OPW-1:0] OP_INC  = 4'd5;
  localparam logic [OPW-1:0] OP_DEC  = 4'd6;
  localparam logic [OPW-1:0] OP_AND  = 4'd7;
  localparam logic [OPW-1:0] OP_OR   = 4'd8;
  localparam logic [OPW-1:0] OP_ST   = 4'd9;
  localparam logic [OPW-1:0] OP_MOV  = 4'd10;
  localparam logic [OPW-1:0] OP_SETC = 4'd11;
  localparam logic [OPW-1:0] OP_CLRC = 4'd12;

  localparam logic [1:0] JCOND_ALWAYS = 2'b00;
  localparam logic [1:0] JCOND_Z      = 2'b01;
  localparam logic [1:0] JCOND_N      = 2'b10;
  localparam logic [1:0] JCOND_C      = 2'b11;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  // One-hot mask of the flag a conditional jump tests; zero for unconditional.
  function automatic logic [2:0] jcond_mask(input logic [1:0] cond);
    logic [2:0] m;
    m = 3'b000;
    case (cond)
      JCOND_Z: m[FLAG_Z] = 1'b1;
      JCOND_N: m[FLAG_N] = 1'b1;
      JCOND_C: m[FLAG_C] = 1'b1;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ccr_update_mask.sv
// Decodes an ALU op code into the set of flags it writes ({C,N,Z} order)
// plus the forced set/clear of carry.
module ccr_update_mask
  import ccr_unit_pkg::*;
#(
  parameter int               W       = OPW,
  parameter logic [W-1:0]     SETC_OP = OP_SETC,
  parameter logic [W-1:0]     CLRC_OP = OP_CLRC
) (
  input  logic [W-1:0] alu_op,
  output logic [2:0]   upd_mask,
  output logic         set_c,
  output logic         clr_c
);

  always_comb begin
    upd_mask = 3'b000;
    set_c    = 1'b0;
    clr_c    = 1'b0;
    if (alu_op == SETC_OP) begin
      set_c = 1'b1;
    end else if (alu_op == CLRC_OP) begin
      clr_c = 1'b1;
    end else begin
      case (alu_op)
        W'(1), W'(7), W'(8):        upd_mask = 3'b011;
        W'(2), W'(3), W'(5), W'(6): upd_mask = 3'b111;
        default:                    upd_mask = 3'b000;
      endcase
    end
  end

endmodule

// File: rtl/ccr_unit.sv
// Condition-code register: latches ALU flags, resolves JZ/JN/JC against
// forwarded flags, and saves/restores flags around interrupts.
module ccr_unit
  import ccr_unit_pkg::*;
#(
  parameter int           OPW_P   = OPW,
  parameter logic [OPW_P-1:0] OP_SETC_P = OP_SETC,
  parameter logic [OPW_P-1:0] OP_CLRC_P = OP_CLRC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [OPW_P-1:0] alu_op,
  input  logic             alu_c,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             jmp_valid,
  input  logic [1:0]       jmp_cond,
  input  logic             int_save,
  input  logic             rti_restore,
  output logic [2:0]       flags,
  output logic             jump_taken
);

  logic [2:0] upd_mask;
  logic       set_c;
  logic       clr_c;
  logic [2:0] alu_flags;
  logic [2:0] fwd;
  logic [2:0] test_mask;
  logic [2:0] flags_next;
  logic [2:0] shadow;
  logic       cond_true;

  ccr_update_mask #(
    .W       (OPW_P),
    .SETC_OP (OP_SETC_P),
    .CLRC_OP (OP_CLRC_P)
  ) u_mask (
    .alu_op   (alu_op),
    .upd_mask (upd_mask),
    .set_c    (set_c),
    .clr_c    (clr_c)
  );

  assign alu_flags = {alu_c, alu_n, alu_z};
  assign test_mask = jcond_mask(jmp_cond);

  always_comb begin
    fwd = (flags & ~upd_mask) | (alu_flags & upd_mask);
    if (set_c) fwd[FLAG_C] = 1'b1;
    if (clr_c) fwd[FLAG_C] = 1'b0;
  end

  // rst_n gate keeps an unconditional jump from firing while held in reset.
  assign cond_true  = (jmp_cond == JCOND_ALWAYS) | (|(fwd & test_mask));
  assign jump_taken = rst_n & jmp_valid & ~stall & cond_true;

  always_comb begin
    flags_next = flags;
    if (stall) begin
      flags_next = flags;
    end else if (rti_restore) begin
      flags_next = shadow;
    end else if (jump_taken) begin
      flags_next = fwd & ~test_mask;
    end else begin
      flags_next = fwd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags  <= 3'b000;
      shadow <= 3'b000;
    end else begin
      flags <= flags_next;
      if (!stall && int_save && !rti_restore) shadow <= flags;
    end
  end

endmodule

// File: tb/tb_ccr_unit.sv
// Directed bench for ccr_unit with hand-computed flag and jump expectations.
module tb_ccr_unit;
  import ccr_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall;
  logic [3:0] alu_op;
  logic       alu_c, alu_z, alu_n;
  logic       jmp_valid;
  logic [1:0] jmp_cond;
  logic       int_save, rti_restore;
  logic [2:0] flags;
  logic       jump_taken;

  int checks = 0;
  int errors = 0;

  ccr_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .alu_op      (alu_op),
    .alu_c       (alu_c),
    .alu_z       (alu_z),
    .alu_n       (alu_n),
    .jmp_valid   (jmp_valid),
    .jmp_cond    (jmp_cond),
    .int_save    (int_save),
    .rti_restore (rti_restore),
    .flags       (flags),
    .jump_taken  (jump_taken)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: op with flags {c,n,z}, jump, save/restore, stall
  task automatic drive(input logic [3:0] op, input logic [2:0] cnz, input logic jv,
                       input logic [1:0] cond, input logic sv, input logic rs, input logic st);
    alu_op = op; alu_c = cnz[2]; alu_n = cnz[1]; alu_z = cnz[0];
    jmp_valid = jv; jmp_cond = cond; int_save = sv; rti_restore = rs; stall = st;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(OP_NOP, 3'b000, 1'b1, JCOND_ALWAYS, 1'b0, 1'b0, 1'b0);
    check("reset_flags", 8'(flags), 8'h0);
    check("reset_jump", 8'(jump_taken), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // op 5 updates all flags; op 4 updates none
    drive(OP_INC, 3'b110, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
    check("op5_all", 8'(flags), 8'h6);
    drive(OP_LD, 3'b111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
    check("op4_hold", 8'(flags), 8'h6);

    // op 7 keeps C; CLRC clears only C
    drive(OP_AND, 3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
    check("op7_keep_c", 8'(flags), 8'h5);
    drive(OP_CLRC, 3'b110, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
    check("clrc", 8'(flags), 8'h1);

    // JZ resolved from the same-cycle ALU result, then Z cleared
    drive(OP_ADD, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
    check("op2_zero", 8'(flags), 8'h0);
    drive(OP_DEC, 3'b001, 1'b1, JCOND_Z, 1'b0, 1'b0, 1'b0);
    check("jz_fwd_taken", 8'(jump_taken), 8'h1);
    tick();
    check("jz_clears_z", 8'(flags), 8'h0);
    drive(OP_NOP, 3'b000, 1'b1, JCOND_N, 1'b0, 1'b0, 1'b0);
    check("jn_not_taken", 8'(jump_taken), 8'h0);

    // interrupt save then restore
    drive(OP_INC, 3'b101, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
    check("set_101", 8'(flags), 8'h5);
    drive(OP_ADD, 3'b010, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0); tick();
    check("save_then_update", 8'(flags), 8'h2);
    drive(OP_INC, 3'b111, 1'b1, JCOND_N, 1'b0, 1'b1, 1'b0);
    check("rti_jump_eval", 8'(jump_taken), 8'h1);
    tick();
    check("rti_restore", 8'(flags), 8'h5);

    // save+restore together: restore wins, shadow stays 101
    drive(OP_INC, 3'b011, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
    check("set_011", 8'(flags), 8'h3);
    drive(OP_NOP, 3'b000, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0); tick();
    check("save_rti_same", 8'(flags), 8'h5);
    drive(OP_INC, 3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
    drive(OP_NOP, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0); tick();
    check("shadow_unchanged", 8'(flags), 8'h5);

    // stall blocks the jump and freezes flags
    drive(OP_ADD, 3'b000, 1'b1, JCOND_C, 1'b0, 1'b0, 1'b1);
    check("stall_no_jump", 8'(jump_taken), 8'h0);
    tick();
    check("stall_hold", 8'(flags), 8'h5);
    drive(OP_NOP, 3'b000, 1'b1, JCOND_C, 1'b0, 1'b0, 1'b0);
    check("jc_taken", 8'(jump_taken), 8'h1);
    tick();
    check("jc_clears_c", 8'(flags), 8'h1);

    // unconditional jump leaves flags alone; SETC forces C
    drive(OP_NOP, 3'b000, 1'b1, JCOND_ALWAYS, 1'b0, 1'b0, 1'b0);
    check("jmp_uncond", 8'(jump_taken), 8'h1);
    tick();
    check("uncond_no_clear", 8'(flags), 8'h1);
    drive(OP_SETC, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
    check("setc", 8'(flags), 8'h5);

    // asynchronous reset mid-cycle with flags=111
    drive(OP_INC, 3'b111, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
    check("set_111", 8'(flags), 8'h7);
    drive(OP_NOP, 3'b000, 1'b1, JCOND_ALWAYS, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_flags", 8'(flags), 8'h0);
    check("async_rst_jump", 8'(jump_taken), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(OP_NOP, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0); tick();
    check("rst_clears_shadow", 8'(flags), 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
